// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, the "no vector" code and the vector encoder
// shared by the interrupt controller.
package irq_ctrl_pkg;

   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_PENDING = 3'd1;
   localparam logic [2:0] REG_MASK    = 3'd2;
   localparam logic [2:0] REG_MODE    = 3'd3;
   localparam logic [2:0] REG_VECTOR  = 3'd4;

   localparam logic [7:0] VECTOR_NONE = 8'h80;

   // Lowest set index in bits [2:0], or VECTOR_NONE when nothing is active.
   function automatic logic [7:0] vec_encode(input logic [7:0] act);
      logic [7:0] v;
      v = VECTOR_NONE;
      for (int i = 7; i >= 0; i--) begin
         if (act[i]) v = 8'(i);
      end
      return v;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchronizer for one active-low interrupt source plus a
// rising-edge detect on the active-high synchronized level.
//   clock    in  system clock
//   reset_n  in  asynchronous active-low reset
//   i_src_n  in  raw active-low request
//   o_level  out synchronized level (s2), 1 = active
//   o_rise   out one-cycle pulse while s2 has just gone 0 -> 1
module irq_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic i_src_n,
   output logic o_level,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_s2_prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s2_prev <= 1'b0;
      end else begin
         r_s1      <= ~i_src_n;
         r_s2      <= r_s1;
         r_s2_prev <= r_s2;
      end
   end

   assign o_level = r_s2;
   // r_s2_prev resets to 0, so a source active across reset release still
   // produces one rise once it propagates through s1/s2.
   assign o_rise  = r_s2 & ~r_s2_prev;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller with per-source level/edge mode, pending,
// mask and priority vector registers, and a registered active-low CPU IRQ.
//   clock      in  system clock
//   reset_n    in  asynchronous active-low reset
//   irq_src_n  in  N_SRC active-low asynchronous requests
//   bus_stb    in  one-cycle strobe per register access
//   rw         in  1 = read, 0 = write
//   addr       in  register offset
//   wdata      in  write data
//   rdata      out read data, combinational from registered state
//   irq_n      out registered active-low interrupt request
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] irq_src_n,
   input  logic             bus_stb,
   input  logic             rw,
   input  logic [2:0]       addr,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata,
   output logic             irq_n
);

   // Bits at and above N_SRC are forced to zero everywhere.
   localparam logic [8:0] SRC_TOP  = 9'd1 << N_SRC;
   localparam logic [7:0] SRC_MASK = SRC_TOP[7:0] - 8'd1;

   logic [N_SRC-1:0] w_level;
   logic [N_SRC-1:0] w_rise;
   logic [7:0]       w_level8;
   logic [7:0]       w_rise8;
   logic [7:0]       w_w1c;
   logic [7:0]       w_mode_chg;
   logic [7:0]       w_pending_d;
   logic             w_wr;
   logic             w_mask_wr;
   logic             w_mode_wr;

   logic [7:0] r_pending;
   logic [7:0] r_mask;
   logic [7:0] r_mode;
   logic       r_irq_n;

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
      irq_sync u_sync (
         .clock   (clock),
         .reset_n (reset_n),
         .i_src_n (irq_src_n[gi]),
         .o_level (w_level[gi]),
         .o_rise  (w_rise[gi])
      );
   end

   always_comb begin
      w_level8              = 8'h00;
      w_rise8               = 8'h00;
      w_level8[N_SRC-1:0]   = w_level;
      w_rise8[N_SRC-1:0]    = w_rise;

      w_wr       = bus_stb & ~rw;
      w_mask_wr  = w_wr && (addr == REG_MASK);
      w_mode_wr  = w_wr && (addr == REG_MODE);
      w_w1c      = (w_wr && (addr == REG_PENDING)) ? (wdata & SRC_MASK) : 8'h00;
      w_mode_chg = w_mode_wr ? ((wdata & SRC_MASK) ^ r_mode) : 8'h00;

      w_pending_d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (w_mode_chg[i]) begin
            w_pending_d[i] = 1'b0;
         end else if (r_mode[i]) begin
            // Set wins over a same-cycle W1C.
            w_pending_d[i] = w_rise8[i] | (r_pending[i] & ~w_w1c[i]);
         end else begin
            w_pending_d[i] = w_level8[i];
         end
      end
      w_pending_d = w_pending_d & SRC_MASK;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= 8'h00;
         r_mask    <= 8'h00;
         r_mode    <= 8'h00;
         r_irq_n   <= 1'b1;
      end else begin
         r_pending <= w_pending_d;
         if (w_mask_wr) r_mask <= wdata & SRC_MASK;
         if (w_mode_wr) r_mode <= wdata & SRC_MASK;
         r_irq_n   <= ~|(r_pending & r_mask);
      end
   end

   always_comb begin
      unique case (addr)
         REG_STATUS:  rdata = w_level8;
         REG_PENDING: rdata = r_pending;
         REG_MASK:    rdata = r_mask;
         REG_MODE:    rdata = r_mode;
         REG_VECTOR:  rdata = vec_encode(r_pending & r_mask);
         default:     rdata = 8'h00;
      endcase
   end

   assign irq_n = r_irq_n;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl. Expected values are queued when
// an access or observation is launched and popped when the DUT output is
// sampled on the falling clock edge.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam int unsigned N_SRC = 6;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [N_SRC-1:0] irq_src_n;
   logic             bus_stb;
   logic             rw;
   logic [2:0]       addr;
   logic [7:0]       wdata;
   logic [7:0]       rdata;
   logic             irq_n;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   irq_ctrl #(.N_SRC(N_SRC)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .irq_src_n (irq_src_n),
      .bus_stb   (bus_stb),
      .rw        (rw),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .irq_n     (irq_n)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h want 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [7:0] exp);
      sb_q.push_back('{tag: tag, exp: exp});
   endtask

   task automatic sb_pop_check(input logic [7:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_empty: got 0x%02h want queued entry", obs);
      end else begin
         e = sb_q.pop_front();
         check_eq(e.tag, obs, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      bus_stb = 1'b1;
      rw      = 1'b0;
      addr    = a;
      wdata   = d;
      tick();
      bus_stb = 1'b0;
      rw      = 1'b1;
   endtask

   task automatic exp_rd(input string tag, input logic [2:0] a, input logic [7:0] e);
      bus_stb = 1'b1;
      rw      = 1'b1;
      addr    = a;
      sb_push(tag, e);
      @(negedge clock);
      sb_pop_check(rdata);
      tick();
      bus_stb = 1'b0;
   endtask

   // Samples irq_n in the current cycle, then advances one edge.
   task automatic exp_irq(input string tag, input logic e);
      sb_push(tag, {7'd0, e});
      @(negedge clock);
      sb_pop_check({7'd0, irq_n});
      tick();
   endtask

   initial begin
      reset_n   = 1'b0;
      irq_src_n = '1;
      bus_stb   = 1'b0;
      rw        = 1'b1;
      addr      = 3'd0;
      wdata     = 8'h00;
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      tick();

      // Reset state
      exp_irq("rst_irq", 1'b1);
      exp_rd("rst_mask", REG_MASK, 8'h00);
      exp_rd("rst_mode", REG_MODE, 8'h00);
      exp_rd("rst_pend", REG_PENDING, 8'h00);
      exp_rd("rst_vec", REG_VECTOR, VECTOR_NONE);

      // Level mode, 4-edge latency both ways
      wr(REG_MASK, 8'h04);
      irq_src_n[2] = 1'b0;
      repeat (3) tick();
      exp_irq("lvl_edge3", 1'b1);
      exp_irq("lvl_edge4", 1'b0);
      exp_rd("lvl_vec", REG_VECTOR, 8'h02);
      exp_rd("lvl_pend", REG_PENDING, 8'h04);
      exp_rd("lvl_status", REG_STATUS, 8'h04);
      wr(REG_PENDING, 8'h04);
      exp_rd("lvl_w1c_noeff", REG_PENDING, 8'h04);
      irq_src_n[2] = 1'b1;
      repeat (3) tick();
      exp_irq("lvl_rel_edge3", 1'b0);
      exp_irq("lvl_rel_edge4", 1'b1);

      // Edge mode: latched after release, W1C drops irq one cycle later
      wr(REG_MODE, 8'h01);
      wr(REG_MASK, 8'h01);
      irq_src_n[0] = 1'b0;
      repeat (3) tick();
      irq_src_n[0] = 1'b1;
      repeat (5) tick();
      exp_rd("edge_latched", REG_PENDING, 8'h01);
      exp_irq("edge_irq", 1'b0);
      wr(REG_PENDING, 8'h01);
      exp_irq("edge_w1c_same", 1'b0);
      exp_irq("edge_w1c_next", 1'b1);

      // Set and W1C in the same cycle: set wins
      wr(REG_MODE, 8'h03);
      wr(REG_MASK, 8'h02);
      irq_src_n[1] = 1'b0;
      repeat (2) tick();
      wr(REG_PENDING, 8'h02);
      exp_rd("sim_set_w1c", REG_PENDING, 8'h02);
      exp_irq("sim_irq", 1'b0);
      irq_src_n[1] = 1'b1;
      repeat (4) tick();
      exp_rd("edge_hold", REG_PENDING, 8'h02);
      // Mode change clears pending of the changed bit
      wr(REG_MODE, 8'h01);
      exp_rd("mode_chg_clr", REG_PENDING, 8'h00);
      exp_rd("mode_rd", REG_MODE, 8'h01);

      // Unimplemented bits and offsets
      wr(REG_MASK, 8'hFF);
      exp_rd("mask_hibits", REG_MASK, 8'h3F);
      wr(REG_MODE, 8'hC1);
      exp_rd("mode_hibits", REG_MODE, 8'h01);
      wr(3'd5, 8'hAA);
      exp_rd("off5", 3'd5, 8'h00);
      exp_rd("off7", 3'd7, 8'h00);

      // Priority
      wr(REG_MODE, 8'h00);
      wr(REG_MASK, 8'h28);
      irq_src_n[3] = 1'b0;
      irq_src_n[5] = 1'b0;
      repeat (4) tick();
      exp_rd("prio_vec3", REG_VECTOR, 8'h03);
      exp_irq("prio_irq_a", 1'b0);
      wr(REG_MASK, 8'h20);
      exp_rd("prio_vec5", REG_VECTOR, 8'h05);
      exp_irq("prio_irq_b", 1'b0);
      wr(REG_MASK, 8'h00);
      exp_rd("prio_none", REG_VECTOR, VECTOR_NONE);
      exp_irq("prio_masked", 1'b1);
      wr(REG_MASK, 8'h20);
      repeat (2) tick();
      exp_irq("pre_rst_irq", 1'b0);

      // Asynchronous reset mid-cycle
      #2;
      reset_n   = 1'b0;
      irq_src_n = '1;
      #1;
      sb_push("rst_async_irq", 8'h01);
      sb_pop_check({7'd0, irq_n});
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      tick();
      exp_rd("rst2_mask", REG_MASK, 8'h00);
      exp_rd("rst2_mode", REG_MODE, 8'h00);
      exp_rd("rst2_pend", REG_PENDING, 8'h00);
      exp_rd("rst2_vec", REG_VECTOR, VECTOR_NONE);
      exp_rd("rst2_status", REG_STATUS, 8'h00);
      exp_irq("rst2_irq", 1'b1);

      // Source held across reset: its edge is gone before MODE can select edge
      reset_n      = 1'b0;
      irq_src_n[0] = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();
      wr(REG_MODE, 8'h01);
      wr(REG_MASK, 8'h01);
      repeat (2) tick();
      exp_rd("held_no_pend", REG_PENDING, 8'h00);
      exp_irq("held_irq", 1'b1);
      irq_src_n[0] = 1'b1;
      repeat (3) tick();
      irq_src_n[0] = 1'b0;
      repeat (4) tick();
      exp_rd("held_new_edge", REG_PENDING, 8'h01);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
